seller_change_disp: RTL
=======================

Name: seller_change_disp

Overview:
Change-dispensing back end for the vending seller. It accepts a vend request carrying a change amount in half-unit coin steps (the d1 unit) and drives a coin hopper. It ejects coins one at a time over an eject/ack handshake, choosing coins greedily (4, 2, 1 units). It also buffers one pending request and guards the hopper with a timeout.

Parameters:
CW, 4, width of the change amount in half-units (max change 2^CW-1)
TO_CYC, 15, max cycles eject may be held without ack before fault (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
vend  input  1  one-cycle request strobe
change  input  CW  change owed with vend, in half-units; sampled only when vend=1
hop_ack  input  1  hopper accepted the currently ejected coin
e1  output  1  eject 1-unit coin (0.5)
e2  output  1  eject 2-unit coin (1.0)
e4  output  1  eject 4-unit coin (2.0)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when a request is fully paid out
ovf  output  1  one-cycle pulse when a request is dropped because the pending slot is full
fault  output  1  sticky hopper timeout flag; cleared only by reset

Behaviour:
- Reset, applied at any time including mid-dispense:
  - state=IDLE; remaining=0; pending empty; timeout counter=0.
  - All outputs 0. Any coin in flight is abandoned.
- States: IDLE, ISSUE, GAP, DONE.
- Outputs e1/e2/e4, busy and done decode from registered state and remaining only. There is no combinational path from any input to any output.
- IDLE:
  - If vend=1 and fault=0 with change!=0: remaining<=change, go to ISSUE.
  - If vend=1 and fault=0 with change==0: go to DONE (no eject).
  - If fault=1: vend is ignored, with no ovf.
- ISSUE:
  - Exactly one eject line is high: e4 if remaining>=4, else e2 if remaining>=2, else e1. It is held stable until ack.
  - hop_ack=1: remaining<=remaining-coin value, timeout counter cleared, go to GAP.
  - hop_ack=0: timeout counter increments. An eject held TO_CYC cycles without ack causes:
    - fault<=1
    - remaining and pending discarded
    - state<=IDLE
    - eject deasserted on the next cycle
  - An ack arriving on the TO_CYC-th cycle counts as success.
- GAP: one cycle with all ejects 0. Then go to DONE if remaining==0, else ISSUE.
- DONE:
  - done=1 for this cycle only.
  - Next state: if pending is valid, load remaining from pending, clear pending, and go to ISSUE (or back to DONE if the pending change==0). Otherwise go to IDLE.
- Pending slot (one deep):
  - vend=1 while busy=1 (including the DONE cycle) and fault=0:
    - slot empty: store change and mark it valid.
    - slot full: ovf=1 for one cycle; the request is dropped and the slot is unchanged.
- hop_ack outside ISSUE is ignored.
- Latency with hop_ack tied high:
  - vend at cycle N gives first eject at N+1.
  - Each coin takes 2 cycles (ISSUE+GAP).
  - done at N+1+2k for k coins.
- Arithmetic: remaining is CW bits wide and never underflows, because the greedy choice guarantees coin value <= remaining.
- Coin count for change c: c/4 fours, then (c%4)/2 twos, then c%2 ones.

Test Plan:
- Reset, hop_ack=1, vend with change=7 at cycle N:
  - e4 at N+1, e2 at N+3, e1 at N+5; all ejects 0 at N+2/4/6.
  - done at N+7; busy falls at N+8.
- vend with change=0 at N -> done=1 at N+1 only; no eject ever; busy=1 for N+1 only.
- change=15 with hop_ack delayed 3 cycles per coin:
  - Sequence is e4,e4,e4,e2,e1, each held exactly until ack.
  - done after the 5th GAP.
- Pending and overflow:
  - vend(change=3) at N, vend(change=5) at N+2, vend(change=1) at N+3 -> ovf pulse at N+4.
  - After done for 3 (e2,e1), the block dispenses 5 (e4,e1) with no IDLE cycle between; the 1-unit request is never served.
- hop_ack held 0 after vend(change=2):
  - e2 high for exactly TO_CYC=15 cycles; then fault=1, ejects 0, busy=0.
  - A later vend is ignored (no eject, no done, no ovf).
- Reset mid-dispense:
  - Assert rst low asynchronously while e4 is high -> all outputs 0 immediately, pending cleared, fault cleared.
  - After release, vend(change=1) -> e1 at the next cycle.

Source files
------------

// File: rtl/seller_change_disp_if.sv
// Handshake bundle between the vend controller and the change dispenser:
// request strobe with change amount in, coin eject lines and status flags out.
interface seller_change_disp_if #(
    parameter int CW = 4
) ();
    logic          vend;
    logic [CW-1:0] change;
    logic          hop_ack;
    logic          e1;
    logic          e2;
    logic          e4;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          fault;

    modport master (
        output vend, change, hop_ack,
        input  e1, e2, e4, busy, done, ovf, fault
    );

    modport slave (
        input  vend, change, hop_ack,
        output e1, e2, e4, busy, done, ovf, fault
    );
endinterface

// File: rtl/seller_change_disp.sv
// Change dispenser: pays out a change amount greedily in 4/2/1 half-unit coins
// over an eject/ack hopper handshake, with a one-deep pending slot and a hopper timeout.
module seller_change_disp #(
    parameter int CW     = 4,
    parameter int TO_CYC = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    seller_change_disp_if.slave  bus
);

    localparam int TW = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q,    state_d;
    logic [CW-1:0] rem_q,      rem_d;
    logic [CW-1:0] pend_q,     pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [TW-1:0] to_cnt_q,   to_cnt_d;
    logic          fault_q,    fault_d;
    logic          ovf_q,      ovf_d;

    logic [CW-1:0] coin_val;
    logic          accept;
    logic          timeout;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            to_cnt_q   <= '0;
            fault_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            to_cnt_q   <= to_cnt_d;
            fault_q    <= fault_d;
            ovf_q      <= ovf_d;
        end
    end

    // Greedy coin choice; the largest coin never exceeds what is still owed.
    always_comb begin
        if (rem_q >= CW'(4))
            coin_val = CW'(4);
        else if (rem_q >= CW'(2))
            coin_val = CW'(2);
        else
            coin_val = CW'(1);
    end

    assign accept  = bus.vend && !fault_q;
    assign timeout = (state_q == ISSUE) && !bus.hop_ack &&
                     (to_cnt_q == TW'(TO_CYC - 1));

    // NOTE: every signal gets a default at the top of the comb block so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        to_cnt_d   = to_cnt_q;
        fault_d    = fault_q;
        ovf_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d   = bus.change;
                    state_d = (bus.change != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (bus.hop_ack) begin
                    rem_d    = rem_q - coin_val;
                    to_cnt_d = '0;
                    state_d  = GAP;
                end else if (timeout) begin
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            GAP: begin
                state_d = (rem_q == '0) ? DONE : ISSUE;
            end
            DONE: begin
                if (pend_vld_q) begin
                    rem_d      = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = (pend_q != '0) ? ISSUE : DONE;
                end else if (accept) begin
                    // A request landing on an empty slot during DONE is consumed directly.
                    rem_d   = bus.change;
                    state_d = (bus.change != '0) ? ISSUE : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept && (state_q != IDLE)) begin
            if (pend_vld_q) begin
                ovf_d = 1'b1;
            end else if (state_q != DONE) begin
                pend_d     = bus.change;
                pend_vld_d = 1'b1;
            end
        end

        // A hopper timeout abandons everything owed and latches the fault.
        if (timeout) begin
            fault_d    = 1'b1;
            rem_d      = '0;
            pend_d     = '0;
            pend_vld_d = 1'b0;
            state_d    = IDLE;
        end
    end

    always_comb begin
        bus.e1    = 1'b0;
        bus.e2    = 1'b0;
        bus.e4    = 1'b0;
        if (state_q == ISSUE) begin
            if (rem_q >= CW'(4))
                bus.e4 = 1'b1;
            else if (rem_q >= CW'(2))
                bus.e2 = 1'b1;
            else
                bus.e1 = 1'b1;
        end
        bus.busy  = (state_q != IDLE);
        bus.done  = (state_q == DONE);
        bus.ovf   = ovf_q;
        bus.fault = fault_q;
    end

endmodule
